// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one word-wide memory port between instruction fetch and
// load/store. It arbitrates, checks legality against the ROM/RAM map, generates
// byte enables and lane-replicated store data, and extends load data.
// Only one transaction is outstanding at a time.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration.
// Without it, the data port has fixed priority over the fetch port.

package typepkg;
  localparam logic [31:0] ROM_END = 32'h0000_1000;  // first address past ROM
  localparam logic [31:0] RAM_END = 32'h0000_3000;  // first address past RAM
  localparam logic [31:0] BAD_VAL = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {W_NONE = 2'd0, W_BYTE = 2'd1, W_HALF = 2'd2, W_WORD = 2'd3} mem_width_t;

  typedef struct packed {
    mem_width_t width;
    logic       is_signed;
  } mem_fmt_t;

  // Command context needed after grant. Address and store data live in the
  // memory command flops.
  typedef struct packed {
    logic       port;  // 0 = fetch, 1 = data
    logic       we;
    mem_fmt_t   fmt;
    logic [1:0] off;
  } mem_cmd_t;
endpackage

module mem_arbiter
  import typepkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  output logic        if_err_o,
  input  logic        d_req_i,
  input  logic [31:0] d_addr_i,
  input  logic        d_we_i,
  input  logic [2:0]  d_fmt_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        d_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE = 2'd0, MEM = 2'd1, RESP = 2'd2} state_t;

  state_t      state_q, state_d;
  mem_cmd_t    cmd_q, cmd_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        if_rvalid_q, if_rvalid_d, if_err_q, if_err_d;
  logic        d_rvalid_q, d_rvalid_d, d_err_q, d_err_d;
  logic [31:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
`ifdef MEM_ARB_RR_EN
  logic        rr_last_q, rr_last_d;  // 1 = data port was granted last
`endif

  logic        gnt_any, win_data;
  logic [31:0] new_addr;
  mem_cmd_t    new_cmd;
  logic        resp_fire, resp_port, resp_err;
  logic [31:0] resp_val;

  function automatic logic legal_f(logic [31:0] a, logic we, mem_fmt_t f);
    logic ok;
    ok = (a < RAM_END) && !(we && (a < ROM_END)) && (f.width != W_NONE);
    if (f.width == W_HALF && a[0]) ok = 1'b0;
    if (f.width == W_WORD && a[1:0] != 2'b00) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [3:0] be_f(mem_fmt_t f, logic [1:0] off);
    logic [3:0] be;
    case (f.width)
      W_BYTE:  be = 4'b0001 << off;
      W_HALF:  be = 4'b0011 << off;
      W_WORD:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] wdata_f(mem_fmt_t f, logic [31:0] wd);
    logic [31:0] r;
    case (f.width)
      W_BYTE:  r = {4{wd[7:0]}};
      W_HALF:  r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_f(mem_fmt_t f, logic [1:0] off, logic [31:0] w);
    logic [31:0] lane, r;
    lane = w >> {off, 3'b000};
    case (f.width)
      W_BYTE:  r = f.is_signed ? {{24{lane[7]}}, lane[7:0]} : {24'h0, lane[7:0]};
      W_HALF:  r = f.is_signed ? {{16{lane[15]}}, lane[15:0]} : {16'h0, lane[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  // Arbitration and the candidate command of the winning port
  always_comb begin
    gnt_any = (state_q == IDLE) && (if_req_i || d_req_i) && !rst;
`ifdef MEM_ARB_RR_EN
    win_data = (if_req_i && d_req_i) ? !rr_last_q : d_req_i;
`else
    win_data = d_req_i;
`endif
    if (win_data) begin
      new_addr      = d_addr_i;
      new_cmd.port  = 1'b1;
      new_cmd.we    = d_we_i;
      new_cmd.fmt   = mem_fmt_t'(d_fmt_i);
    end else begin
      new_addr      = if_addr_i;
      new_cmd.port  = 1'b0;
      new_cmd.we    = 1'b0;
      new_cmd.fmt   = '{width: W_WORD, is_signed: 1'b0};
    end
    new_cmd.off = new_addr[1:0];
  end

  assign if_gnt_o = gnt_any && !win_data;
  assign d_gnt_o  = gnt_any && win_data;

  // Next-state, memory command and response formation
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rvalid_d = 1'b0;
    if_err_d    = 1'b0;
    d_rvalid_d  = 1'b0;
    d_err_d     = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
`ifdef MEM_ARB_RR_EN
    rr_last_d   = rr_last_q;
`endif
    resp_fire   = 1'b0;
    resp_port   = cmd_q.port;
    resp_err    = 1'b0;
    resp_val    = 32'h0;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          cmd_d = new_cmd;
`ifdef MEM_ARB_RR_EN
          rr_last_d = win_data;
`endif
          if (legal_f(new_addr, new_cmd.we, new_cmd.fmt)) begin
            state_d     = MEM;
            mem_req_d   = 1'b1;
            mem_we_d    = new_cmd.we;
            mem_be_d    = be_f(new_cmd.fmt, new_cmd.off);
            mem_addr_d  = {new_addr[31:2], 2'b00};
            mem_wdata_d = wdata_f(new_cmd.fmt, win_data ? d_wdata_i : 32'h0);
          end else begin
            // Illegal access: answer directly, never touch memory
            state_d   = RESP;
            resp_fire = 1'b1;
            resp_port = new_cmd.port;
            resp_err  = 1'b1;
            resp_val  = BAD_VAL;
          end
        end
      end
      MEM: begin
        if (mem_ack_i) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          resp_fire = 1'b1;
          resp_val  = cmd_q.we ? 32'h0 : load_f(cmd_q.fmt, cmd_q.off, mem_rdata_i);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (resp_fire) begin
      if (resp_port) begin
        d_rvalid_d = 1'b1;
        d_err_d    = resp_err;
        d_rdata_d  = resp_val;
      end else begin
        if_rvalid_d = 1'b1;
        if_err_d    = resp_err;
        if_rdata_d  = resp_val;
      end
    end
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'h0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      if_rvalid_q <= 1'b0;
      if_err_q    <= 1'b0;
      d_rvalid_q  <= 1'b0;
      d_err_q     <= 1'b0;
      if_rdata_q  <= 32'h0;
      d_rdata_q   <= 32'h0;
`ifdef MEM_ARB_RR_EN
      rr_last_q   <= 1'b1;  // fetch wins the first tie
`endif
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rvalid_q <= if_rvalid_d;
      if_err_q    <= if_err_d;
      d_rvalid_q  <= d_rvalid_d;
      d_err_q     <= d_err_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
`ifdef MEM_ARB_RR_EN
      rr_last_q   <= rr_last_d;
`endif
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_be_o    = mem_be_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_rvalid_o = if_rvalid_q;
  assign if_err_o    = if_err_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rvalid_o  = d_rvalid_q;
  assign d_err_o     = d_err_q;
  assign d_rdata_o   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed test-plan steps, then random single-port
// transactions checked against a word-array memory model and spec-level
// arithmetic for legality, byte enables, store replication and load extension.
module tb_mem_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        if_req = 1'b0, if_gnt_o, if_rvalid_o, if_err_o;
  logic [31:0] if_addr = 32'h0, if_rdata_o;
  logic        d_req = 1'b0, d_we = 1'b0, d_gnt_o, d_rvalid_o, d_err_o;
  logic [31:0] d_addr = 32'h0, d_wdata = 32'h0, d_rdata_o;
  logic [2:0]  d_fmt = 3'b0;
  logic        mem_req_o, mem_we_o, mem_ack = 1'b0;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata = 32'h0;

  int checks = 0, errors = 0;
  logic [31:0] mem [0:3071];
  logic [31:0] exp_if = 32'h0, exp_d = 32'h0;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
    .d_req_i(d_req), .d_addr_i(d_addr), .d_we_i(d_we), .d_fmt_i(d_fmt),
    .d_wdata_i(d_wdata), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o),
    .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference rules, written from the address map and format tables
  function automatic bit m_legal(logic [31:0] a, bit we, int w);
    if (a >= 32'h3000) return 0;
    if (we && a < 32'h1000) return 0;
    if (w == 0) return 0;
    if (w == 2 && a % 2 != 0) return 0;
    if (w == 3 && a % 4 != 0) return 0;
    return 1;
  endfunction

  function automatic logic [3:0] m_be(int w, int off);
    if (w == 1) return 4'(1 << off);
    if (w == 2) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(int w, logic [31:0] wd);
    if (w == 1) return (wd & 32'hFF) * 32'h0101_0101;
    if (w == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(int w, bit s, int off, logic [31:0] word);
    logic [31:0] v;
    if (w == 3) return word;
    v = word >> (8 * off);
    if (w == 1) begin
      v = v & 32'hFF;
      if (s && v >= 128) v = v | 32'hFFFF_FF00;
    end else begin
      v = v & 32'hFFFF;
      if (s && v >= 32768) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // Response cycle check: owner strobes, the other port stays quiet and holds rdata
  task automatic chk_resp(input bit port, input bit err, input logic [31:0] val);
    if (port) begin
      exp_d = val;
      chk("d_rvalid", d_rvalid_o, 1); chk("d_err", d_err_o, err);
      chk("d_rdata", d_rdata_o, exp_d);
      chk("if_rvalid_idle", if_rvalid_o, 0); chk("if_rdata_hold", if_rdata_o, exp_if);
    end else begin
      exp_if = val;
      chk("if_rvalid", if_rvalid_o, 1); chk("if_err", if_err_o, err);
      chk("if_rdata", if_rdata_o, exp_if);
      chk("d_rvalid_idle", d_rvalid_o, 0); chk("d_rdata_hold", d_rdata_o, exp_d);
    end
  endtask

  // One transaction on one port; called and returns at posedge+1 in IDLE
  task automatic do_txn(input bit port, input logic [31:0] a, input bit we_i,
                        input logic [2:0] fmt, input logic [31:0] wd, input int dly);
    int w, off, widx;
    bit s, we, legal;
    logic [31:0] rv, wdv;
    logic [3:0] be;
    w = port ? int'(fmt[2:1]) : 3;
    s = port ? fmt[0] : 1'b0;
    we = port ? we_i : 1'b0;
    off = int'(a % 4);
    legal = m_legal(a, we, w);
    if (port) begin
      d_req = 1; d_addr = a; d_we = we; d_fmt = fmt; d_wdata = wd;
    end else begin
      if_req = 1; if_addr = a;
    end
    #1;
    chk("gnt_if", if_gnt_o, !port);
    chk("gnt_d", d_gnt_o, port);
    @(posedge clk); #1;
    if_req = 0; d_req = 0;
    if (!legal) begin
      chk("err_no_mem_req", mem_req_o, 0);
      chk_resp(port, 1, 32'hDEAD_BEEF);
    end else begin
      be = m_be(w, off);
      wdv = m_wdata(w, wd);
      chk("mem_req", mem_req_o, 1);
      chk("mem_we", mem_we_o, we);
      chk("mem_be", mem_be_o, be);
      chk("mem_addr", mem_addr_o, a & ~32'h3);
      if (we) chk("mem_wdata", mem_wdata_o, wdv);
      for (int i = 0; i < dly; i++) begin
        @(posedge clk); #1;
        chk("mem_req_hold", mem_req_o, 1);
      end
      widx = int'(a[13:2]);
      mem_rdata = mem[widx];
      mem_ack = 1;
      rv = we ? 32'h0 : m_load(w, s, off, mem[widx]);
      if (we) for (int b = 0; b < 4; b++) if (be[b]) mem[widx][8*b +: 8] = wdv[8*b +: 8];
      @(posedge clk); #1;
      mem_ack = 0; mem_rdata = $urandom;
      chk("mem_req_drop", mem_req_o, 0);
      chk_resp(port, 0, rv);
    end
    @(posedge clk); #1;
    chk("rvalid_one_cycle", port ? d_rvalid_o : if_rvalid_o, 0);
  endtask

  initial begin
    int gp[$];
    int gc[$];
    bit stop;
    for (int i = 0; i < 3072; i++) mem[i] = $urandom;
    mem[4] = 32'h0000_0013;
    mem[32'h400] = 32'h80FF_FFFF;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", mem_req_o, 0); chk("rst_mem_we", mem_we_o, 0);
    chk("rst_mem_be", mem_be_o, 0); chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_mem_wdata", mem_wdata_o, 0);
    rst = 0;
    #1;
    chk("rst_gnt", {if_gnt_o, d_gnt_o}, 0);
    chk("rst_rvalid", {if_rvalid_o, d_rvalid_o, if_err_o, d_err_o}, 0);
    chk("rst_if_rdata", if_rdata_o, 0); chk("rst_d_rdata", d_rdata_o, 0);

    // Directed test-plan steps
    do_txn(0, 32'h10, 0, 3'b110, 0, 0);
    chk("fetch_word", if_rdata_o, 32'h13);
    do_txn(1, 32'h1003, 0, 3'b011, 0, 1);
    chk("lb_signed", d_rdata_o, 32'hFFFF_FF80);
    do_txn(1, 32'h1003, 0, 3'b010, 0, 0);
    chk("lbu", d_rdata_o, 32'h0000_0080);
    do_txn(1, 32'h1002, 1, 3'b100, 32'h1234_ABCD, 2);
    do_txn(1, 32'h1000, 0, 3'b110, 0, 0);
    chk("sh_result", d_rdata_o, 32'hABCD_FFFF);
    do_txn(1, 32'h4, 1, 3'b110, 32'h55, 0);
    do_txn(1, 32'h1001, 0, 3'b110, 0, 0);
    chk("lw_misaligned", d_rdata_o, 32'hDEAD_BEEF);
    do_txn(0, 32'h12, 0, 3'b110, 0, 0);
    do_txn(1, 32'h1000, 0, 3'b000, 0, 0);
    do_txn(1, 32'h3000, 0, 3'b010, 0, 0);
    do_txn(1, 32'h2FFC, 1, 3'b110, 32'hCAFE_F00D, 0);
    do_txn(0, 32'hFFC, 0, 3'b110, 0, 3);

    // Reset during MEM with ack pending
    d_req = 1; d_addr = 32'h1000; d_we = 0; d_fmt = 3'b110;
    #1; chk("rstmid_gnt", d_gnt_o, 1);
    @(posedge clk); #1;
    d_req = 0;
    chk("rstmid_mem_req", mem_req_o, 1);
    rst = 1;
    #1;
    chk("rstmid_req_drop", mem_req_o, 0); chk("rstmid_be", mem_be_o, 0);
    chk("rstmid_addr", mem_addr_o, 0); chk("rstmid_rvalid", d_rvalid_o, 0);
    chk("rstmid_d_rdata", d_rdata_o, 0); chk("rstmid_if_rdata", if_rdata_o, 0);
    exp_if = 0; exp_d = 0;
    @(posedge clk); #1;
    rst = 0; mem_ack = 1;
    @(posedge clk); #1;
    mem_ack = 0;
    chk("stray_ack_rvalid", {if_rvalid_o, d_rvalid_o}, 0);
    chk("stray_ack_req", mem_req_o, 0);

    // Both ports requesting continuously, ack one cycle after mem_req
    stop = 0;
    if_req = 1; if_addr = 32'h10; d_req = 1; d_addr = 32'h1000; d_we = 0; d_fmt = 3'b110;
    for (int i = 0; i < 40; i++) begin
      mem_ack = mem_req_o;
      mem_rdata = mem[int'(mem_addr_o[13:2])];
      #1;
      if (if_gnt_o || d_gnt_o) begin gp.push_back(int'(d_gnt_o)); gc.push_back(i); end
      if (if_rvalid_o) exp_if = mem[4];
      if (d_rvalid_o) exp_d = mem[32'h400];
      if (gp.size() == 6) stop = 1;
      @(posedge clk); #1;
      if (stop) begin if_req = 0; d_req = 0; end
    end
    mem_ack = 0;
    chk("arb_grants", gp.size(), 6);
    for (int k = 0; k < gp.size(); k++) begin
`ifdef MEM_ARB_RR_EN
      chk("arb_port", gp[k], k % 2);
`else
      chk("arb_port", gp[k], 1);
`endif
      if (k > 0) chk("arb_spacing", gc[k] - gc[k-1], 3);
    end
    chk("arb_if_rdata", if_rdata_o, exp_if);
    chk("arb_d_rdata", d_rdata_o, exp_d);

    // Random single-port transactions
    for (int n = 0; n < 60; n++) begin
      int sel;
      logic [31:0] a;
      sel = $urandom_range(0, 9);
      if (sel < 3)      a = $urandom_range(0, 32'hFFF);
      else if (sel < 9) a = $urandom_range(32'h1000, 32'h2FFF);
      else              a = $urandom_range(32'h3000, 32'h3FFF);
      if ($urandom_range(0, 1) == 1) a = a & ~32'h3;
      do_txn(1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)),
             3'($urandom_range(0, 7)), $urandom, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter for the RV32I core: shares one word-wide memory port (ROM 0x0000_0000–0x0000_0FFF, RAM 0x0000_1000–0x0000_2FFF) between the instruction-fetch and load/store units. Arbitrates, decodes the address map, generates byte enables and aligned store data, and returns sign- or zero-extended load data. One transaction is outstanding at a time. Illegal accesses end in an error response without any memory cycle.

## Interface
- No parameters. Map constants and `BAD_VAL` (0xDEAD_BEEF) come from `typepkg`.
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `if_req_i`  in  1  fetch request, level
- `if_addr_i`  in  32  fetch address; always a word access
- `if_gnt_o`  out  1  one-cycle accept pulse
- `if_rvalid_o`  out  1  one-cycle response strobe
- `if_rdata_o`  out  32  instruction word
- `if_err_o`  out  1  error qualifier, valid with `if_rvalid_o`
- `d_req_i`  in  1  data request, level
- `d_addr_i`  in  32  byte address
- `d_we_i`  in  1  1 = store
- `d_fmt_i`  in  3  `mem_fmt_t` {width, is_signed}
- `d_wdata_i`  in  32  store data, LSB-aligned
- `d_gnt_o`, `d_rvalid_o`, `d_err_o`  out  1 each  same meaning as the fetch-port equivalents
- `d_rdata_o`  out  32  extended load data
- `mem_req_o`  out  1  memory command valid
- `mem_we_o`  out  1  write
- `mem_be_o`  out  4  byte enables
- `mem_addr_o`  out  32  word address, bits [1:0] = 0
- `mem_wdata_o`  out  32  lane-replicated store data
- `mem_ack_i`  in  1  command done; `mem_rdata_i` is valid in the same cycle
- `mem_rdata_i`  in  32  read word

## Operation
- FSM states: IDLE, MEM, RESP.
- **IDLE, arbitration**
  - Pick a winner from the active requests.
  - Pulse the winner's `gnt` combinationally in the same cycle.
  - Latch port ID, address, we, fmt, wdata and byte offset `addr[1:0]`.
- **IDLE, legality check** (done at grant time):
  - Address must be < 0x3000.
  - No store to ROM (address < 0x1000).
  - width must not be NONE.
  - Alignment: half needs `addr[0]`=0; word needs `addr[1:0]`=0.
  - Legal → MEM. Illegal → RESP with error set, no memory cycle.
- **MEM**
  - `mem_req_o`=1 with the latched command, held stable until `mem_ack_i`.
  - On ack: register the formatted read data, go to RESP.
- **RESP**
  - Pulse `rvalid` on the owning port for one cycle, with rdata and err. Then go to IDLE.
  - `err`=1 → rdata = 0xDEAD_BEEF.
  - A completed store returns rdata = 0 and err = 0.
- **Byte enables:** byte = 4'b0001 << off; half = 4'b0011 << off; word = 4'b1111.
- **Store data:** byte → {4{wdata[7:0]}}; half → {2{wdata[15:0]}}; word → unchanged.
- **Load data:** select the lane at the byte offset. Sign-extend when is_signed=1, otherwise zero-extend. Word loads pass through unchanged.
- **Request hold rule:** a request still asserted after its `gnt` is treated as a new request, accepted only on the next return to IDLE.
- **Defaults:** the non-owning port's `rvalid`/`err` stay 0. Its rdata holds its last value.

## Timing
- Reset values:
  - state = IDLE
  - all `gnt`, `rvalid`, `err`, `mem_req_o`, `mem_we_o` = 0
  - `mem_be_o` = 0, `mem_addr_o` = 0, `mem_wdata_o` = 0
  - `if_rdata_o` = `d_rdata_o` = 0
  - round-robin pointer selects the fetch port
- Legal access: grant in cycle N; `mem_req_o` from N+1; ack in cycle M ≥ N+1; `rvalid` in M+1.
- Minimum legal access: 3 cycles from grant to next grant opportunity (grant N, ack N+1, rvalid N+2, next grant N+3).
- Error access: grant N, `rvalid`+`err` in N+1, next grant N+2.
- Asserting `rst` mid-transaction: outputs return to reset values asynchronously and the pending transaction is dropped. No `rvalid` is produced for it.
- Behaviour is undefined if `mem_ack_i` arrives while `mem_req_o`=0. The arbiter ignores such an ack.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - Round-robin arbitration.
  - On simultaneous requests, the port not granted last wins.
  - The pointer updates on every grant.
- Undefined:
  - Fixed priority: the data port always beats the fetch port.
  - No pointer flop exists.

## Test plan
- Fetch word at 0x0000_0010, mem returns 0x0000_0013 with ack at N+1 → `if_rvalid_o` at N+2, `if_rdata_o`=0x0000_0013, `if_err_o`=0.
- LB, signed, at 0x1003, mem word 0x80FF_FFFF → `d_rdata_o`=0xFFFF_FF80. Same access as LBU → 0x0000_0080.
- SH at 0x1002, wdata 0x1234_ABCD → `mem_be_o`=4'b1100, `mem_wdata_o`=0xABCD_ABCD, `mem_we_o`=1.
- SW to 0x0000_0004 (ROM) and LW at 0x1001 → no `mem_req_o`; `d_err_o`=1 and `d_rdata_o`=0xDEAD_BEEF at grant+1.
- Both ports requesting continuously, ack one cycle after each `mem_req_o`:
  - with `MEM_ARB_RR_EN` → grants alternate fetch, data, fetch, …
  - without it → data port is granted every time.
- `rst` asserted during MEM with ack pending → `mem_req_o`=0 immediately, no `rvalid`, next request granted normally from IDLE.
